register_bank_debug: RTL

//   MIPS register bank: two combinational read ports (A/B), one write-back port,
//   and a debug dump port that streams all registers out over a valid/ready handshake.

---
 rtl/register_bank_debug_pkg.sv | 14 +
 rtl/register_bank_dump_sequencer.sv | 80 ++++++++
 rtl/register_bank_debug.sv | 83 ++++++++
 3 files changed

// File: rtl/register_bank_debug_pkg.sv
// rtl/register_bank_debug_pkg.sv - shared widths and dump FSM state encoding for the register bank
package register_bank_debug_pkg;

    localparam int CANTIDAD_REGISTROS              = 32;
    localparam int CANTIDAD_BITS_REGISTROS         = 32;
    localparam int CANTIDAD_BITS_ADDRESS_REGISTROS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/register_bank_dump_sequencer.sv
// rtl/register_bank_dump_sequencer.sv - streams every register out over a valid/ready dump port
module register_bank_dump_sequencer
    import register_bank_debug_pkg::*;
#(
    parameter int CANTIDAD_REGISTROS              = register_bank_debug_pkg::CANTIDAD_REGISTROS,
    parameter int CANTIDAD_BITS_REGISTROS         = register_bank_debug_pkg::CANTIDAD_BITS_REGISTROS,
    parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = register_bank_debug_pkg::CANTIDAD_BITS_ADDRESS_REGISTROS
) (
    input  logic                                       i_clock,
    input  logic                                       i_soft_reset,
    input  logic                                       i_dump_start,
    input  logic                                       i_dump_ready,
    input  logic                                       i_control_write,
    input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_reg_Write,
    input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_data_write,
    output logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] o_rd_addr,
    input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_rd_data,
    output logic                                       o_dump_valid,
    output logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] o_dump_addr,
    output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_dump_data,
    output logic                                       o_dump_done
);

    localparam logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] LAST_ADDR =
        CANTIDAD_BITS_ADDRESS_REGISTROS'(CANTIDAD_REGISTROS - 1);

    dump_state_t                                state;
    dump_state_t                                state_next;
    logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] dump_addr;
    logic [CANTIDAD_BITS_REGISTROS-1:0]         dump_data;
    logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] next_addr;
    logic [CANTIDAD_BITS_REGISTROS-1:0]         next_data;
    logic                                       accept;

    // The beat address doubles as the dump pointer.
    assign next_addr = dump_addr + CANTIDAD_BITS_ADDRESS_REGISTROS'(1);
    assign o_rd_addr = next_addr;
    assign accept    = (state == SEND) && i_dump_ready;

    // A write landing on the register about to be loaded wins over the stale array value.
    assign next_data = (i_control_write && (i_reg_Write == next_addr) && (next_addr != '0))
                       ? i_data_write : i_rd_data;

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_dump_start) state_next = SEND;
            SEND:    if (accept && (dump_addr == LAST_ADDR)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            dump_addr <= '0;
            dump_data <= '0;
        end else if ((state == IDLE) && i_dump_start) begin
            dump_addr <= '0;
            dump_data <= '0;
        end else if (accept && (dump_addr != LAST_ADDR)) begin
            dump_addr <= next_addr;
            dump_data <= next_data;
        end
    end

    assign o_dump_valid = (state == SEND);
    assign o_dump_done  = (state == DONE);
    assign o_dump_addr  = dump_addr;
    assign o_dump_data  = dump_data;

endmodule

// File: rtl/register_bank_debug.sv
// rtl/register_bank_debug.sv - MIPS register bank with bypassed read ports and a debug dump port
module register_bank_debug
    import register_bank_debug_pkg::*;
#(
    parameter int CANTIDAD_REGISTROS              = register_bank_debug_pkg::CANTIDAD_REGISTROS,
    parameter int CANTIDAD_BITS_REGISTROS         = register_bank_debug_pkg::CANTIDAD_BITS_REGISTROS,
    parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = register_bank_debug_pkg::CANTIDAD_BITS_ADDRESS_REGISTROS
) (
    input  logic                                       i_clock,
    input  logic                                       i_soft_reset,
    input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_reg_A,
    input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_reg_B,
    input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_reg_Write,
    input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_data_write,
    input  logic                                       i_control_write,
    output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_data_A,
    output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_data_B,
    output logic                                       o_led,
    input  logic                                       i_dump_start,
    input  logic                                       i_dump_ready,
    output logic                                       o_dump_valid,
    output logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] o_dump_addr,
    output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_dump_data,
    output logic                                       o_dump_done
);

    logic [CANTIDAD_BITS_REGISTROS-1:0]         regs [CANTIDAD_REGISTROS];
    logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] dump_rd_addr;
    logic [CANTIDAD_BITS_REGISTROS-1:0]         dump_rd_data;
    logic                                       write_en;

    // Register 0 is never written, so it stays at its reset value of zero.
    assign write_en = i_control_write && (i_reg_Write != '0);

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            for (int i = 0; i < CANTIDAD_REGISTROS; i++) begin
                regs[i] <= '0;
            end
            o_led <= 1'b0;
        end else if (write_en) begin
            regs[i_reg_Write] <= i_data_write;
            o_led             <= 1'b1;
        end
    end

    always_comb begin
        o_data_A = regs[i_reg_A];
        if (write_en && (i_reg_Write == i_reg_A)) begin
            o_data_A = i_data_write;
        end
    end

    always_comb begin
        o_data_B = regs[i_reg_B];
        if (write_en && (i_reg_Write == i_reg_B)) begin
            o_data_B = i_data_write;
        end
    end

    assign dump_rd_data = regs[dump_rd_addr];

    register_bank_dump_sequencer #(
        .CANTIDAD_REGISTROS              (CANTIDAD_REGISTROS),
        .CANTIDAD_BITS_REGISTROS         (CANTIDAD_BITS_REGISTROS),
        .CANTIDAD_BITS_ADDRESS_REGISTROS (CANTIDAD_BITS_ADDRESS_REGISTROS)
    ) u_dump_sequencer (
        .i_clock         (i_clock),
        .i_soft_reset    (i_soft_reset),
        .i_dump_start    (i_dump_start),
        .i_dump_ready    (i_dump_ready),
        .i_control_write (i_control_write),
        .i_reg_Write     (i_reg_Write),
        .i_data_write    (i_data_write),
        .o_rd_addr       (dump_rd_addr),
        .i_rd_data       (dump_rd_data),
        .o_dump_valid    (o_dump_valid),
        .o_dump_addr     (o_dump_addr),
        .o_dump_data     (o_dump_data),
        .o_dump_done     (o_dump_done)
    );

endmodule
